// File: rtl/window_pkg.sv
// window_pkg: shared pixel types and constants for the 3x3 window generator.
//   PIX_W    - pixel width (raw FP32 bits)
//   pixel_t  - one pixel
//   PIX_ZERO - all-zero pixel used for reset values
package window_pkg;

    localparam int unsigned PIX_W = 32;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t PIX_ZERO = '0;

endpackage

// File: rtl/line_fifo.sv
// line_fifo: enable-gated delay line of DEPTH pixels.
//   clk         - clock
//   pixel_valid - shift enable; storage holds when low
//   pixel_in    - pixel entering the line
//   pixel_out   - pixel accepted DEPTH enables earlier
// Storage has no reset: stale contents are masked by the window's row gating.
module line_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned PIX_W = window_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             pixel_valid,
    input  logic [PIX_W-1:0] pixel_in,
    output logic [PIX_W-1:0] pixel_out
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] mem_d [DEPTH];

    // Shift by one position; index 0 is the newest pixel.
    always_comb begin
        mem_d[0] = pixel_in;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            mem_q <= mem_d;
        end
    end

    assign pixel_out = mem_q[DEPTH-1];

endmodule

// File: rtl/window_3x3.sv
// window_3x3: streaming 3x3 neighbourhood generator for raster-order pixels.
//   clk          - clock
//   rst          - asynchronous active-low reset
//   pixel_in     - incoming pixel (raw FP32 bits)
//   pixel_valid  - pixel_in accepted on this edge
//   sof          - start-of-frame, forces position (0,0); only with WINDOW_SOF_EN
//   OUT_1..OUT_9 - window pixels, row-major, OUT_1 top-left, OUT_9 newest
//   output_valid - one-cycle pulse when OUT_* hold a new window
//   frame_done   - pulses with the last window of a frame
// Optional feature macro: WINDOW_SOF_EN (adds the sof port).
module window_3x3
    import window_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
`ifdef WINDOW_SOF_EN
    input  logic             sof,
`endif
    output logic [PIX_W-1:0] OUT_1,
    output logic [PIX_W-1:0] OUT_2,
    output logic [PIX_W-1:0] OUT_3,
    output logic [PIX_W-1:0] OUT_4,
    output logic [PIX_W-1:0] OUT_5,
    output logic [PIX_W-1:0] OUT_6,
    output logic [PIX_W-1:0] OUT_7,
    output logic [PIX_W-1:0] OUT_8,
    output logic [PIX_W-1:0] OUT_9,
    output logic             output_valid,
    output logic             frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    pixel_t           win_q [9];
    pixel_t           win_d [9];
    pixel_t           out_q [9];
    pixel_t           out_d [9];
    logic             valid_q, valid_d;
    logic             frame_done_q, frame_done_d;
    pixel_t           tap1, tap2;
    logic             restart_c;

    // tap1 is the pixel one row above the current one, tap2 two rows above.
    line_fifo #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk         (clk),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .pixel_out   (tap1)
    );

    line_fifo #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb2 (
        .clk         (clk),
        .pixel_valid (pixel_valid),
        .pixel_in    (tap1),
        .pixel_out   (tap2)
    );

`ifdef WINDOW_SOF_EN
    assign restart_c = pixel_valid & sof;
`else
    assign restart_c = 1'b0;
`endif

    // Position tracking, window shift and window emission.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_d        = out_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        // A start-of-frame pixel is treated as (0,0); the abandoned frame
        // never reaches its last position, so it never raises frame_done.
        col_cur      = restart_c ? '0 : col_q;
        row_cur      = restart_c ? '0 : row_q;

        if (pixel_valid) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = tap2;
            win_d[5] = tap1;
            win_d[8] = pixel_in;

            if (row_cur >= ROW_W'(2) && col_cur >= COL_W'(2)) begin
                valid_d      = 1'b1;
                out_d        = win_d;
                frame_done_d = (row_cur == ROW_W'(IMG_HEIGHT-1)) &&
                               (col_cur == COL_W'(IMG_WIDTH-1));
            end

            if (col_cur == COL_W'(IMG_WIDTH-1)) begin
                col_d = '0;
                row_d = (row_cur == ROW_W'(IMG_HEIGHT-1)) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: PIX_ZERO};
            out_q        <= '{default: PIX_ZERO};
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign OUT_1        = out_q[0];
    assign OUT_2        = out_q[1];
    assign OUT_3        = out_q[2];
    assign OUT_4        = out_q[3];
    assign OUT_5        = out_q[4];
    assign OUT_6        = out_q[5];
    assign OUT_7        = out_q[6];
    assign OUT_8        = out_q[7];
    assign OUT_9        = out_q[8];
    assign output_valid = valid_q;
    assign frame_done   = frame_done_q;

endmodule
